// File: rtl/tlb_write_ctrl_pkg.sv
// tlb_write_ctrl_pkg: shared op codes, FSM states and TLB field layouts
package tlb_write_ctrl_pkg;
  localparam int TLB_ENTRIES = 16;
  localparam int ASID_W = 8;
  localparam int VPN2_W = 19;
  localparam int PM_W = 16;
  localparam int LO_W = 26;
  localparam int HI_W = VPN2_W + ASID_W;
  localparam int HDR_W = 1 + ASID_W + VPN2_W + PM_W;
  localparam int HDR_PM_LSB = 0;
  localparam int HDR_VPN2_LSB = HDR_PM_LSB + PM_W;
  localparam int HDR_ASID_LSB = HDR_VPN2_LSB + VPN2_W;
  localparam int HDR_G_BIT = HDR_ASID_LSB + ASID_W;
  typedef enum logic [1:0] {
    OP_TLBR  = 2'b00,
    OP_TLBWI = 2'b01,
    OP_TLBWR = 2'b10,
    OP_TLBP  = 2'b11
  } tlb_op_e;
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    PROBE,
    READ,
    RDWAIT,
    DONE
  } state_e;
endpackage

// File: rtl/tlb_write_ctrl_prio_enc.sv
// tlb_prio_enc: lowest-index-wins priority encoder over the probe match vector
module tlb_prio_enc #(
  parameter int ENTRIES = 16,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] match,
  output logic               hit,
  output logic [IW-1:0]      idx
);
  // scan from the top so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (match[i]) idx = i[IW-1:0];
  end
  assign hit = |match;
endmodule

// File: rtl/tlb_write_ctrl.sv
// tlb_write_ctrl: sequences TLBR/TLBWI/TLBWR/TLBP against the TLB arrays and tracks CP0 Random
module tlb_write_ctrl
  import tlb_write_ctrl_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [1:0]         op,
  output logic               op_ready,
  input  logic [IW-1:0]      cp0_index,
  input  logic [IW-1:0]      cp0_wired,
  input  logic               wired_we,
  input  logic [ASID_W-1:0]  cp0_asid,
  input  logic [VPN2_W-1:0]  cp0_vpn2,
  input  logic [PM_W-1:0]    cp0_pagemask,
  input  logic               cp0_g,
  input  logic [LO_W-1:0]    cp0_lo0,
  input  logic [LO_W-1:0]    cp0_lo1,
  output logic [ENTRIES-1:0] hdr_we,
  output logic [ASID_W-1:0]  hdr_asid,
  output logic [VPN2_W-1:0]  hdr_vpn2,
  output logic               hdr_g,
  output logic [PM_W-1:0]    hdr_pagemask,
  output logic [ASID_W-1:0]  probe_asid,
  output logic [VPN2_W-1:0]  probe_vpn2,
  input  logic [ENTRIES-1:0] probe_match,
  output logic               lo_we,
  output logic [IW-1:0]      lo_addr,
  output logic [LO_W-1:0]    lo0,
  output logic [LO_W-1:0]    lo1,
  output logic [IW-1:0]      rd_addr,
  input  logic [HDR_W-1:0]   rd_hdr,
  input  logic [LO_W-1:0]    rd_lo0,
  input  logic [LO_W-1:0]    rd_lo1,
  output logic               res_valid,
  output logic [HI_W-1:0]    res_hi,
  output logic [PM_W-1:0]    res_pagemask,
  output logic [LO_W-1:0]    res_lo0,
  output logic [LO_W-1:0]    res_lo1,
  output logic [IW:0]        res_index,
  output logic [IW-1:0]      random
);
  localparam logic [IW-1:0] TOP = IW'(ENTRIES - 1);
  state_e state, state_nx;
  tlb_op_e op_in;
  logic accept, hit;
  logic [IW-1:0] idx_q, hit_idx;
  logic [ASID_W-1:0] asid_q;
  logic [VPN2_W-1:0] vpn2_q;
  logic [PM_W-1:0] pm_q;
  logic g_q;
  logic [LO_W-1:0] lo0_q, lo1_q;
  assign op_in = tlb_op_e'(op);
  assign op_ready = state == IDLE;
  assign accept = op_valid & op_ready;
  // state register; reset aborts any op in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: writes take one cycle, probe two, read three
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = op_in == OP_TLBP ? PROBE : op_in == OP_TLBR ? READ : WRITE;
      WRITE:   state_nx = IDLE;
      PROBE:   state_nx = DONE;
      READ:    state_nx = RDWAIT;
      RDWAIT:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // capture CP0 fields and target index at acceptance; TLBWR uses Random as it stands before any wired update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx_q <= '0;
      asid_q <= '0;
      vpn2_q <= '0;
      pm_q <= '0;
      g_q <= 1'b0;
      lo0_q <= '0;
      lo1_q <= '0;
    end else if (accept) begin
      idx_q <= op_in == OP_TLBWR ? random : cp0_index;
      asid_q <= cp0_asid;
      vpn2_q <= cp0_vpn2;
      pm_q <= cp0_pagemask;
      g_q <= cp0_g;
      lo0_q <= cp0_lo0;
      lo1_q <= cp0_lo1;
    end
  // Random counts down to Wired then wraps to the top; a Wired write restarts it at the top
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) random <= TOP;
    else random <= (wired_we || random == cp0_wired) ? TOP : random - 1'b1;
  tlb_prio_enc #(.ENTRIES(ENTRIES)) u_prio_enc (
    .match(probe_match),
    .hit  (hit),
    .idx  (hit_idx)
  );
  // results: probe index at the end of PROBE, entry readback at the end of RDWAIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      res_index <= '0;
      res_hi <= '0;
      res_pagemask <= '0;
      res_lo0 <= '0;
      res_lo1 <= '0;
    end else if (state == PROBE) begin
      res_index <= {~hit, hit ? hit_idx : '0};
    end else if (state == RDWAIT) begin
      res_hi <= {rd_hdr[HDR_VPN2_LSB +: VPN2_W], rd_hdr[HDR_ASID_LSB +: ASID_W]};
      res_pagemask <= rd_hdr[HDR_PM_LSB +: PM_W];
      res_lo0 <= rd_lo0;
      res_lo1 <= rd_lo1;
    end
  assign hdr_we = state == WRITE ? {{(ENTRIES-1){1'b0}}, 1'b1} << idx_q : '0;
  assign lo_we = state == WRITE;
  assign lo_addr = idx_q;
  assign rd_addr = idx_q;
  assign hdr_asid = asid_q;
  assign hdr_vpn2 = vpn2_q;
  assign hdr_g = g_q;
  assign hdr_pagemask = pm_q;
  assign lo0 = lo0_q;
  assign lo1 = lo1_q;
  assign probe_asid = asid_q;
  assign probe_vpn2 = vpn2_q;
  assign res_valid = state == WRITE || state == DONE;
endmodule

// File: tb/tb_tlb_write_ctrl.sv
// tb_tlb_write_ctrl: directed checks of op sequencing, probe encoding, readback and Random
module tb_tlb_write_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic op_valid = 1'b0;
  logic [1:0] op = 2'b00;
  logic op_ready;
  logic [3:0] cp0_index = '0, cp0_wired = '0;
  logic wired_we = 1'b0;
  logic [7:0] cp0_asid = '0;
  logic [18:0] cp0_vpn2 = '0;
  logic [15:0] cp0_pagemask = '0;
  logic cp0_g = 1'b0;
  logic [25:0] cp0_lo0 = '0, cp0_lo1 = '0;
  logic [15:0] hdr_we;
  logic [7:0] hdr_asid, probe_asid;
  logic [18:0] hdr_vpn2, probe_vpn2;
  logic hdr_g;
  logic [15:0] hdr_pagemask;
  logic [15:0] probe_match = '0;
  logic lo_we;
  logic [3:0] lo_addr, rd_addr, random;
  logic [25:0] lo0, lo1, rd_lo0 = '0, rd_lo1 = '0, res_lo0, res_lo1;
  logic [43:0] rd_hdr = '0;
  logic res_valid;
  logic [26:0] res_hi;
  logic [15:0] res_pagemask;
  logic [4:0] res_index;
  int n_cmp = 0;
  int n_err = 0;

  tlb_write_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .op_ready(op_ready),
    .cp0_index(cp0_index), .cp0_wired(cp0_wired), .wired_we(wired_we),
    .cp0_asid(cp0_asid), .cp0_vpn2(cp0_vpn2), .cp0_pagemask(cp0_pagemask), .cp0_g(cp0_g),
    .cp0_lo0(cp0_lo0), .cp0_lo1(cp0_lo1), .hdr_we(hdr_we), .hdr_asid(hdr_asid),
    .hdr_vpn2(hdr_vpn2), .hdr_g(hdr_g), .hdr_pagemask(hdr_pagemask),
    .probe_asid(probe_asid), .probe_vpn2(probe_vpn2), .probe_match(probe_match),
    .lo_we(lo_we), .lo_addr(lo_addr), .lo0(lo0), .lo1(lo1), .rd_addr(rd_addr),
    .rd_hdr(rd_hdr), .rd_lo0(rd_lo0), .rd_lo1(rd_lo1), .res_valid(res_valid),
    .res_hi(res_hi), .res_pagemask(res_pagemask), .res_lo0(res_lo0), .res_lo1(res_lo1),
    .res_index(res_index), .random(random)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    cp0_wired = 4'd3;
    @(negedge clk);
    chk("rst_op_ready", 64'(op_ready), 64'd1);
    chk("rst_random", 64'(random), 64'd15);
    chk("rst_hdr_we", 64'(hdr_we), 64'd0);
    chk("rst_lo_we", 64'(lo_we), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_index", 64'(res_index), 64'd0);
    chk("rst_res_hi", 64'(res_hi), 64'd0);
    chk("rst_hdr_vpn2", 64'(hdr_vpn2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_ready", 64'(op_ready), 64'd1);
    for (int k = 0; k < 14; k++) begin
      chk("random_seq", 64'(random), k <= 12 ? 64'(15 - k) : 64'd15);
      @(negedge clk);
    end
    chk("random_before_wired", 64'(random), 64'd14);
    wired_we = 1'b1;
    @(negedge clk);
    chk("random_wired_we", 64'(random), 64'd15);
    wired_we = 1'b0;
    cp0_wired = 4'd0;

    op_valid = 1'b1; op = 2'b01; cp0_index = 4'd5; cp0_vpn2 = 19'h12345; cp0_asid = 8'h3A;
    cp0_pagemask = 16'h1FFF; cp0_g = 1'b1; cp0_lo0 = 26'h1234567; cp0_lo1 = 26'h2ABCDEF;
    @(negedge clk);
    chk("wi_hdr_we", 64'(hdr_we), 64'h0020);
    chk("wi_lo_we", 64'(lo_we), 64'd1);
    chk("wi_lo_addr", 64'(lo_addr), 64'd5);
    chk("wi_res_valid", 64'(res_valid), 64'd1);
    chk("wi_op_ready", 64'(op_ready), 64'd0);
    chk("wi_hdr_vpn2", 64'(hdr_vpn2), 64'h12345);
    chk("wi_hdr_asid", 64'(hdr_asid), 64'h3A);
    chk("wi_hdr_g", 64'(hdr_g), 64'd1);
    chk("wi_hdr_pm", 64'(hdr_pagemask), 64'h1FFF);
    chk("wi_lo0", 64'(lo0), 64'h1234567);
    chk("wi_lo1", 64'(lo1), 64'h2ABCDEF);
    op_valid = 1'b0; cp0_index = 4'd0; cp0_lo0 = '0;
    @(negedge clk);
    chk("wi_after_hdr_we", 64'(hdr_we), 64'd0);
    chk("wi_after_lo_we", 64'(lo_we), 64'd0);
    chk("wi_after_res_valid", 64'(res_valid), 64'd0);
    chk("wi_after_ready", 64'(op_ready), 64'd1);

    op_valid = 1'b1; op = 2'b11; cp0_vpn2 = 19'h5A5A5; cp0_asid = 8'h77; probe_match = '0;
    @(negedge clk);
    chk("p_probe_vpn2", 64'(probe_vpn2), 64'h5A5A5);
    chk("p_probe_asid", 64'(probe_asid), 64'h77);
    chk("p_t1_res_valid", 64'(res_valid), 64'd0);
    probe_match = 16'h0840; op = 2'b01;
    @(negedge clk);
    chk("p_res_valid", 64'(res_valid), 64'd1);
    chk("p_res_index", 64'(res_index), 64'b0_0110);
    chk("p_busy_hdr_we", 64'(hdr_we), 64'd0);
    op_valid = 1'b0; probe_match = '0;
    @(negedge clk);
    chk("p_after_res_valid", 64'(res_valid), 64'd0);
    chk("p_after_hdr_we", 64'(hdr_we), 64'd0);
    op_valid = 1'b1; op = 2'b11;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    chk("p_miss_res_valid", 64'(res_valid), 64'd1);
    chk("p_miss_res_index", 64'(res_index), 64'b1_0000);
    @(negedge clk);

    op_valid = 1'b1; op = 2'b00; cp0_index = 4'd9;
    @(negedge clk);
    chk("r_rd_addr", 64'(rd_addr), 64'd9);
    chk("r_t1_res_valid", 64'(res_valid), 64'd0);
    chk("r_t1_hdr_we", 64'(hdr_we), 64'd0);
    op_valid = 1'b0;
    @(negedge clk);
    rd_hdr = {1'b1, 8'hC3, 19'h7F00F, 16'h00FF}; rd_lo0 = 26'h0ABCDE1; rd_lo1 = 26'h3000002;
    chk("r_t2_res_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("r_res_valid", 64'(res_valid), 64'd1);
    chk("r_res_hi", 64'(res_hi), 64'({19'h7F00F, 8'hC3}));
    chk("r_res_pm", 64'(res_pagemask), 64'h00FF);
    chk("r_res_lo0", 64'(res_lo0), 64'h0ABCDE1);
    chk("r_res_lo1", 64'(res_lo1), 64'h3000002);
    chk("r_res_index_kept", 64'(res_index), 64'b1_0000);
    @(negedge clk);
    chk("r_after_res_valid", 64'(res_valid), 64'd0);

    wired_we = 1'b1;
    @(negedge clk);
    wired_we = 1'b0;
    chk("wr_random_top", 64'(random), 64'd15);
    repeat (8) @(negedge clk);
    chk("wr_random_7", 64'(random), 64'd7);
    op_valid = 1'b1; op = 2'b10; wired_we = 1'b1; cp0_index = 4'd2;
    @(negedge clk);
    chk("wr_hdr_we", 64'(hdr_we), 64'h0080);
    chk("wr_lo_addr", 64'(lo_addr), 64'd7);
    chk("wr_random", 64'(random), 64'd15);
    chk("wr_res_valid", 64'(res_valid), 64'd1);
    chk("wr_res_hi_kept", 64'(res_hi), 64'({19'h7F00F, 8'hC3}));
    op_valid = 1'b0; wired_we = 1'b0;
    @(negedge clk);

    op_valid = 1'b1; op = 2'b00; cp0_index = 4'd4;
    @(negedge clk);
    op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(op_ready), 64'd1);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_res_hi", 64'(res_hi), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_release_ready", 64'(op_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_res_valid", 64'(res_valid), 64'd0);
      chk("abort_no_we", 64'({hdr_we, lo_we}), 64'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
